// File: rtl/pcie_rx_credit_return.sv
// pcie_rx_credit_return: VC0 receive-side credit manager.
// Snoops the 16-bit RX TLP stream, classifies each TLP from header DW0 and
// returns the consumed header/data credits to the core as one-cycle pulses.
module pcie_rx_credit_return #(
   parameter int unsigned MAX_PD_NUM = 128,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_125,
   input  logic             sys_rst,
   input  logic             rx_st,
   input  logic             rx_end,
   input  logic [15:0]      rx_data,
   output logic             ph_cr,
   output logic             pd_cr,
   output logic             nph_cr,
   output logic             npd_cr,
   output logic [7:0]       pd_num,
   output logic [CNT_W-1:0] p_tlp_cnt,
   output logic [CNT_W-1:0] np_tlp_cnt,
   output logic [CNT_W-1:0] bad_tlp_cnt
);

   localparam logic [8:0] MAX9 = 9'(MAX_PD_NUM);
   localparam logic [7:0] MAX8 = 8'(MAX_PD_NUM);

   typedef enum logic [1:0] {C_IDLE, C_W1, C_BODY, C_DONE} cap_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_SPLIT} ret_state_t;

   // Credit descriptor handed from capture to return side
   typedef struct packed {
      logic       p;
      logic       np;
      logic       pd;
      logic       npd;
      logic [8:0] cred;
   } desc_t;

   cap_state_t cap_q, cap_nxt;
   ret_state_t ret_q, ret_nxt;

   logic [1:0]  fmt_q;
   logic [4:0]  type_q;
   logic [9:0]  len_q;

   logic        hand_now, src_from_bus, use_bus_len, data_ok, trunc;
   logic        latch_hdr, latch_len, drop_new;
   logic [1:0]  hfmt;
   logic [4:0]  htype;
   logic [9:0]  hlen;
   logic        is_mem, is_msg, is_npw, is_cpl, h_unk;
   logic [10:0] dw, dw3;
   desc_t       h_desc;

   logic        hq_vld;
   desc_t       hq;
   desc_t       cur_q, pend_q;
   logic        pend_vld;
   logic        load_cur, load_from_pend, pend_set, pend_clr, pend_drop;
   logic        over, finishing;
   logic [8:0]  split_rem;
   logic [2:0]  bad_inc;

   // Capture FSM state register
   always_ff @(posedge clk_125) begin
      if (sys_rst) cap_q <= C_IDLE;
      else         cap_q <= cap_nxt;
   end

   // Capture FSM next state, header latching and handoff/abort detection
   always_comb begin
      cap_nxt      = cap_q;
      hand_now     = 1'b0;
      src_from_bus = 1'b0;
      use_bus_len  = 1'b0;
      data_ok      = 1'b0;
      trunc        = 1'b0;
      latch_hdr    = 1'b0;
      latch_len    = 1'b0;
      drop_new     = 1'b0;
      case (cap_q)
         C_IDLE, C_DONE: begin
            cap_nxt = C_IDLE;
            if (rx_st && rx_end) begin
               // Header-only TLP: decode straight from the bus, no data credits
               hand_now     = 1'b1;
               src_from_bus = 1'b1;
               trunc        = 1'b1;
               cap_nxt      = C_DONE;
            end else if (rx_st) begin
               latch_hdr = 1'b1;
               cap_nxt   = C_W1;
            end
         end
         C_W1: begin
            if (rx_st) begin
               // Previous TLP lost before its length word: header credit only
               hand_now = 1'b1;
               trunc    = 1'b1;
               if (rx_end) begin
                  drop_new = 1'b1;
                  cap_nxt  = C_IDLE;
               end else begin
                  latch_hdr = 1'b1;
                  cap_nxt   = C_W1;
               end
            end else begin
               latch_len = 1'b1;
               if (rx_end) begin
                  hand_now    = 1'b1;
                  use_bus_len = 1'b1;
                  data_ok     = 1'b1;
                  cap_nxt     = C_DONE;
               end else begin
                  cap_nxt = C_BODY;
               end
            end
         end
         C_BODY: begin
            if (rx_st) begin
               hand_now = 1'b1;
               trunc    = 1'b1;
               data_ok  = 1'b1;
               if (rx_end) begin
                  // Only one handoff per cycle: a new 1-word TLP here is dropped
                  drop_new = 1'b1;
                  cap_nxt  = C_IDLE;
               end else begin
                  latch_hdr = 1'b1;
                  cap_nxt   = C_W1;
               end
            end else if (rx_end) begin
               hand_now = 1'b1;
               data_ok  = 1'b1;
               cap_nxt  = C_DONE;
            end
         end
         default: cap_nxt = C_IDLE;
      endcase
   end

   // Classify the TLP being handed off and compute its data credits
   always_comb begin
      hfmt   = src_from_bus ? rx_data[14:13] : fmt_q;
      htype  = src_from_bus ? rx_data[12:8]  : type_q;
      hlen   = use_bus_len  ? rx_data[9:0]   : len_q;
      is_mem = (htype == 5'b00000) || (htype == 5'b00001);
      is_msg = (htype[4:3] == 2'b10);
      is_npw = (htype == 5'b00010) || (htype == 5'b00100) || (htype == 5'b00101);
      is_cpl = (htype == 5'b01010) || (htype == 5'b01011);
      h_desc = '0;
      h_unk  = 1'b0;
      if (is_mem && hfmt[1]) begin
         h_desc.p  = 1'b1;
         h_desc.pd = data_ok;
      end else if (is_msg) begin
         h_desc.p  = 1'b1;
         h_desc.pd = hfmt[1] & data_ok;
      end else if (is_mem) begin
         h_desc.np = 1'b1;
      end else if (is_npw) begin
         h_desc.np  = 1'b1;
         h_desc.npd = hfmt[1] & data_ok;
      end else if (!is_cpl) begin
         h_unk = 1'b1;
         if (hfmt[1]) h_desc.p  = 1'b1;
         else         h_desc.np = 1'b1;
      end
      dw          = (hlen == 10'd0) ? 11'd1024 : {1'b0, hlen};
      dw3         = dw + 11'd3;
      h_desc.cred = dw3[10:2];
   end

   // Latched header fields of the TLP under capture
   always_ff @(posedge clk_125) begin
      if (sys_rst) begin
         fmt_q  <= '0;
         type_q <= '0;
         len_q  <= '0;
      end else begin
         if (latch_hdr) begin
            fmt_q  <= rx_data[14:13];
            type_q <= rx_data[12:8];
         end
         if (latch_len) len_q <= rx_data[9:0];
      end
   end

   // Handoff register: completions never reach the return side
   always_ff @(posedge clk_125) begin
      if (sys_rst) begin
         hq_vld <= 1'b0;
         hq     <= '0;
      end else begin
         hq_vld <= hand_now & (h_desc.p | h_desc.np);
         hq     <= h_desc;
      end
   end

   // Return FSM state register, current descriptor and one-entry pending slot
   always_ff @(posedge clk_125) begin
      if (sys_rst) begin
         ret_q    <= R_IDLE;
         cur_q    <= '0;
         pend_q   <= '0;
         pend_vld <= 1'b0;
      end else begin
         ret_q <= ret_nxt;
         if (load_cur) cur_q <= load_from_pend ? pend_q : hq;
         if (pend_set) begin
            pend_vld <= 1'b1;
            pend_q   <= hq;
         end else if (pend_clr) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // Return FSM next state and credit strobes
   always_comb begin
      ret_nxt        = ret_q;
      load_cur       = 1'b0;
      load_from_pend = 1'b0;
      pend_set       = 1'b0;
      pend_clr       = 1'b0;
      pend_drop      = 1'b0;
      ph_cr          = 1'b0;
      pd_cr          = 1'b0;
      nph_cr         = 1'b0;
      npd_cr         = 1'b0;
      pd_num         = '0;
      over           = cur_q.pd && (cur_q.cred > MAX9);
      split_rem      = cur_q.cred - MAX9;
      finishing      = 1'b0;
      case (ret_q)
         R_ISSUE: begin
            ph_cr     = cur_q.p;
            nph_cr    = cur_q.np;
            pd_cr     = cur_q.pd;
            npd_cr    = cur_q.npd;
            if (cur_q.pd) pd_num = over ? MAX8 : cur_q.cred[7:0];
            finishing = !over;
         end
         R_SPLIT: begin
            pd_cr     = 1'b1;
            pd_num    = split_rem[7:0];
            finishing = 1'b1;
         end
         default: ;
      endcase
      // Pending entry is older than a fresh handoff, so it is issued first
      if (ret_q == R_IDLE || finishing) begin
         ret_nxt = R_IDLE;
         if (pend_vld) begin
            load_cur       = 1'b1;
            load_from_pend = 1'b1;
            ret_nxt        = R_ISSUE;
            if (hq_vld) pend_set = 1'b1;
            else        pend_clr = 1'b1;
         end else if (hq_vld) begin
            load_cur = 1'b1;
            ret_nxt  = R_ISSUE;
         end
      end else begin
         ret_nxt = R_SPLIT;
         if (hq_vld) begin
            if (!pend_vld) pend_set  = 1'b1;
            else           pend_drop = 1'b1;
         end
      end
   end

   assign bad_inc = {2'b0, trunc} + {2'b0, hand_now & h_unk} +
                    {2'b0, drop_new} + {2'b0, pend_drop};

   // Statistics counters
   always_ff @(posedge clk_125) begin
      if (sys_rst) begin
         p_tlp_cnt   <= '0;
         np_tlp_cnt  <= '0;
         bad_tlp_cnt <= '0;
      end else begin
         if (ret_q == R_ISSUE && cur_q.p)  p_tlp_cnt  <= p_tlp_cnt + 1'b1;
         if (ret_q == R_ISSUE && cur_q.np) np_tlp_cnt <= np_tlp_cnt + 1'b1;
         bad_tlp_cnt <= bad_tlp_cnt + CNT_W'(bad_inc);
      end
   end

endmodule
